baud_tick_gen: RTL and testbench
================================

# baud_tick_gen

Parametrised baud-rate tick generator for the UART. It produces an oversampling tick (`os_tick`), a once-per-bit tick (`bit_tick`) and a mid-bit sample tick (`mid_tick`) from a programmable integer-plus-fractional divisor. The divisor is staged in a shadow register, and a `restart` input resynchronises the phase for RX start-bit alignment. One instance sits in front of the UART TX serializer and one in front of the RX deserializer.

## Interface
- `DIV_W`, 16: integer divisor width.
- `FRAC_W`, 4: fractional divisor width, in 1/2^FRAC_W cycle units.
- `OVS`, 16: oversampling ratio. Even, ≥ 2.
- `RESET_DIV`, 325: active integer divisor after reset. Active fraction resets to 0.

Ports (reset reset, asynchronous, active-high; clock clk):
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable; counter holds while low.
- `restart`  in  1  synchronous phase restart, one-cycle pulse.
- `div_int`  in  DIV_W  integer divisor, shadow input.
- `div_frac`  in  FRAC_W  fractional divisor, shadow input.
- `div_load`  in  1  capture `div_int`/`div_frac` into the shadow register.
- `os_tick`  out  1  oversample tick, one-cycle pulse.
- `mid_tick`  out  1  pulse on os_tick number OVS/2 of each bit.
- `bit_tick`  out  1  pulse on os_tick number OVS of each bit.

## Operation
- State:
  - `cnt` (DIV_W): down-counter.
  - `acc` (FRAC_W): fractional accumulator.
  - `ovs_cnt` (clog2(OVS)): oversample counter.
  - Active divisor `A_int`/`A_frac`.
  - Shadow divisor `S_int`/`S_frac`, plus a pending flag.
- Period length: L = max(A_int, 1) + carry.
  - carry is the overflow from acc + A_frac, computed at each period end.
  - Average period is A_int + A_frac/2^FRAC_W cycles.
  - `div_int` = 0 is treated as 1.
- Each enabled cycle:
  - If `cnt` ≠ 0: decrement `cnt`.
  - If `cnt` = 0: assert `os_tick` next cycle, update `acc` = `acc` + A_frac (mod 2^FRAC_W), reload `cnt` = L−1, advance `ovs_cnt`.
- `ovs_cnt` counts 0..OVS−1 and wraps.
  - `mid_tick` accompanies the `os_tick` that ends `ovs_cnt` = OVS/2−1.
  - `bit_tick` accompanies the `os_tick` that ends `ovs_cnt` = OVS−1.
- `div_load`:
  - Writes the shadow and sets pending.
  - At the next reload, the shadow is copied to the active divisor and pending is cleared, so the current period is never truncated.
  - A later `div_load` before that reload overwrites the shadow; last write wins.
- `restart` (priority over `en` and reload):
  - If pending, shadow is copied to active first.
  - `acc` = 0, `ovs_cnt` = 0, `cnt` = max(A_int, 1)−1.
  - No tick is emitted in the restart cycle.
- `restart` together with `div_load` in the same cycle: the new `div_int`/`div_frac` are used directly.
- `en` low: all state is frozen and the tick outputs are 0. `div_load` is still accepted.

## Timing
- Reset values:
  - Outputs: `os_tick` = `mid_tick` = `bit_tick` = 0.
  - State: `cnt` = RESET_DIV−1, `acc` = 0, `ovs_cnt` = 0, pending = 0.
- All outputs are registered and are never high for two consecutive cycles unless L = 1.
- With `en` held high from the first edge after reset:
  - `os_tick` is high after edges L, 2L, … (fraction 0).
  - `bit_tick` first goes high after edge OVS·L.
- After a `restart` edge, the first `os_tick` is high after L further enabled edges.
- Reset asserted mid-period: immediate return to the reset values. No partial tick.

## Configuration
- `BAUD_FRAC_EN` defined: fractional accumulator present, behaviour as above.
- `BAUD_FRAC_EN` undefined:
  - `acc` and `S_frac`/`A_frac` are removed and `div_frac` is ignored.
  - carry is always 0, so L = max(A_int, 1) exactly.

## Structure
- `uart_pkg` holds:
  - The `DIV_W`/`FRAC_W`/`OVS` defaults and `RESET_DIV`.
  - The `baud_div_t` struct {int, frac}.
  - The helper function `calc_div(clk_hz, baud, ovs)`.
- Sub-module `baud_frac_acc`: the accumulator plus carry. It is instantiated only under `BAUD_FRAC_EN`.
- Everything else stays flat in `baud_tick_gen`.

## Test plan
- Reset, `en`=1, defaults → `os_tick` every 325 cycles; first `bit_tick` at cycle 5200.
- `div_load` with `div_int`=4, `div_frac`=8 (FRAC_W=4) → periods alternate 4,5,4,5; 16 `os_tick`s take 72 cycles.
- `div_load` issued mid-period (`cnt`=100, old A_int=325, new 10) → current period completes at 325, then 10-cycle periods follow.
- `restart` pulse while `ovs_cnt`=9 → `mid_tick` occurs exactly 8·L cycles later and `bit_tick` 16·L cycles later.
- `en` low for 50 cycles mid-period → tick is delayed by exactly 50 cycles; no ticks while low.
- `div_int`=0, FRAC=0 → `os_tick` high every cycle. Without `BAUD_FRAC_EN`, `div_frac`=8 has no effect and the period is exactly `div_int`.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg - shared UART baud-rate definitions.
//
// Contents:
//   BAUD_DIV_W, BAUD_FRAC_W, BAUD_OVS, BAUD_RESET_DIV : default generator sizing
//   baud_div_t : divisor pair {int_div, frac}, frac in 1/2^BAUD_FRAC_W cycle units
//   calc_div   : divisor for a given clock, baud rate and oversampling ratio
package uart_pkg;

  localparam int BAUD_DIV_W     = 16;
  localparam int BAUD_FRAC_W    = 4;
  localparam int BAUD_OVS       = 16;
  localparam int BAUD_RESET_DIV = 325;

  typedef struct packed {
    logic [BAUD_DIV_W-1:0]  int_div;
    logic [BAUD_FRAC_W-1:0] frac;
  } baud_div_t;

  // Clock cycles per oversample tick, in fixed point with BAUD_FRAC_W
  // fraction bits. The result is rounded to the nearest fraction step.
  function automatic baud_div_t calc_div(input longint clk_hz, input longint baud,
                                         input int ovs);
    longint    den;
    longint    scaled;
    baud_div_t d;
    den    = baud * longint'(ovs);
    scaled = (den == 0) ? 64'd0
                        : (clk_hz * (64'd1 << BAUD_FRAC_W) + den / 2) / den;
    d.int_div = scaled[BAUD_FRAC_W +: BAUD_DIV_W];
    d.frac    = scaled[BAUD_FRAC_W-1:0];
    return d;
  endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// baud_frac_acc - fractional phase accumulator for baud_tick_gen.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the accumulator (phase restart)
//   step       : add frac to the accumulator (period end)
//   frac       : fractional divisor to accumulate
//   carry      : overflow of acc + frac; lengthens the period that starts now
module baud_frac_acc
  import uart_pkg::*;
#(
  parameter int FRAC_W = BAUD_FRAC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, frac};
  assign carry = sum[FRAC_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen - UART baud tick generator with integer + fractional divisor.
//
// Build option: BAUD_FRAC_EN adds the fractional accumulator; without it the
// fraction input is ignored and every period is exactly max(div_int, 1).
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   en         : count enable; all state holds and ticks are 0 while low
//   restart    : one-cycle phase restart (RX start-bit alignment)
//   div_int    : integer divisor, captured by div_load
//   div_frac   : fractional divisor, captured by div_load
//   div_load   : write the shadow divisor; it goes live at the next period end
//   os_tick    : oversample tick, one cycle per period
//   mid_tick   : with the os_tick closing oversample slot OVS/2-1
//   bit_tick   : with the os_tick closing oversample slot OVS-1
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int DIV_W     = BAUD_DIV_W,
  parameter int FRAC_W    = BAUD_FRAC_W,
  parameter int OVS       = BAUD_OVS,
  parameter int RESET_DIV = BAUD_RESET_DIV
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick
);

  localparam int OVS_W = $clog2(OVS);
  localparam logic [OVS_W-1:0] MID_CNT   = OVS_W'(OVS / 2 - 1);
  localparam logic [OVS_W-1:0] LAST_CNT  = OVS_W'(OVS - 1);
  localparam logic [DIV_W-1:0] RESET_INT = DIV_W'(RESET_DIV);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [OVS_W-1:0] ovs_cnt;
  logic [DIV_W-1:0] a_int;
  logic [DIV_W-1:0] s_int;
  logic             pending;

  logic [DIV_W-1:0] eff_int;
  logic [DIV_W-1:0] eff_base;
  logic [DIV_W-1:0] rst_int;
  logic [DIV_W-1:0] rst_base;
  logic [DIV_W-1:0] reload_cnt;
  logic             reload;
  logic             carry;

  // A pending shadow takes effect at the reload, so the period starting at
  // that reload already uses the new divisor.
  assign eff_int  = pending ? s_int : a_int;
  assign eff_base = (eff_int == '0) ? ONE : eff_int;

  // On restart a simultaneous div_load bypasses the shadow.
  assign rst_int  = div_load ? div_int : eff_int;
  assign rst_base = (rst_int == '0) ? ONE : rst_int;

  assign reload     = en && !restart && (cnt == '0);
  // eff_base >= 1, so eff_base - 1 + carry never overflows.
  assign reload_cnt = eff_base - ONE + DIV_W'(carry);

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] a_frac;
  logic [FRAC_W-1:0] s_frac;
  logic [FRAC_W-1:0] eff_frac;
  logic [FRAC_W-1:0] rst_frac;

  assign eff_frac = pending ? s_frac : a_frac;
  assign rst_frac = div_load ? div_frac : eff_frac;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_frac <= '0;
      s_frac <= '0;
    end else begin
      if (div_load) begin
        s_frac <= div_frac;
      end
      if (restart) begin
        a_frac <= rst_frac;
      end else if (reload) begin
        a_frac <= eff_frac;
      end
    end
  end

  baud_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk   (clk),
    .reset (reset),
    .clear (restart),
    .step  (reload),
    .frac  (eff_frac),
    .carry (carry)
  );
`else
  logic [FRAC_W-1:0] unused_div_frac;

  assign unused_div_frac = div_frac;
  assign carry           = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= RESET_INT - ONE;
      ovs_cnt  <= '0;
      a_int    <= RESET_INT;
      s_int    <= RESET_INT;
      pending  <= 1'b0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;

      if (div_load) begin
        s_int <= div_int;
      end

      if (restart) begin
        a_int   <= rst_int;
        pending <= 1'b0;
        cnt     <= rst_base - ONE;
        ovs_cnt <= '0;
      end else if (en) begin
        if (cnt != '0) begin
          cnt <= cnt - ONE;
        end else begin
          os_tick  <= 1'b1;
          mid_tick <= (ovs_cnt == MID_CNT);
          bit_tick <= (ovs_cnt == LAST_CNT);
          ovs_cnt  <= (ovs_cnt == LAST_CNT) ? '0 : ovs_cnt + OVS_W'(1);
          cnt      <= reload_cnt;
          a_int    <= eff_int;
          pending  <= 1'b0;
        end
      end

      // A load outside restart always leaves a pending shadow, even when it
      // coincides with a reload (that reload used the previous shadow).
      if (div_load && !restart) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen - directed tests for baud_tick_gen with default parameters
// (DIV_W=16, FRAC_W=4, OVS=16, RESET_DIV=325).
module tb_baud_tick_gen;

`ifdef BAUD_FRAC_EN
  localparam int EXP_FRAC_P2  = 5;
  localparam int EXP_FRAC_TOT = 72;
`else
  localparam int EXP_FRAC_P2  = 4;
  localparam int EXP_FRAC_TOT = 64;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        restart = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        div_load = 1'b0;
  logic        os_tick;
  logic        mid_tick;
  logic        bit_tick;

  int n_checks = 0;
  int n_fail   = 0;

  baud_tick_gen dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .restart  (restart),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

  always #5 clk = ~clk;

  // Counts falling edges until the selected tick is seen (0=os, 1=mid,
  // 2=bit). Returns -1 if the budget runs out.
  task automatic wait_ev(input int sel, input int budget, output int n);
    logic hit;
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = os_tick;
        1:       hit = mid_tick;
        default: hit = bit_tick;
      endcase
      if (hit === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Restart with a new divisor loaded in the same cycle; returns on the
  // falling edge right after the restart edge.
  task automatic restart_with(input int d, input int f);
    div_int  = 16'(d);
    div_frac = 4'(f);
    div_load = 1'b1;
    restart  = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    restart  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (os_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_os_tick: got %b want 0", os_tick);
    end
    n_checks++;
    if (mid_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_tick: got %b want 0", mid_tick);
    end
    n_checks++;
    if (bit_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bit_tick: got %b want 0", bit_tick);
    end
    reset = 1'b0;
    en    = 1'b1;
  endtask

  task automatic test_default();
    int n;
    wait_ev(0, 400, n);
    n_checks++;
    if (n !== 325) begin
      n_fail++;
      $display("FAIL default_first_os: got %0d want 325", n);
    end
    wait_ev(1, 3000, n);
    n_checks++;
    if (n !== 2275) begin
      n_fail++;
      $display("FAIL default_first_mid: got %0d want 2275", n);
    end
    n_checks++;
    if (os_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL default_mid_with_os: got %b want 1", os_tick);
    end
    wait_ev(2, 3000, n);
    n_checks++;
    if (n !== 2600) begin
      n_fail++;
      $display("FAIL default_first_bit: got %0d want 2600", n);
    end
    @(negedge clk);
    n_checks++;
    if ({os_tick, bit_tick} !== 2'b00) begin
      n_fail++;
      $display("FAIL default_tick_width: got %b want 00", {os_tick, bit_tick});
    end
  endtask

  task automatic test_load_mid();
    int n;
    int seen;
    restart_with(325, 0);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (os_tick === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL load_mid_early_tick: got %0d want 0", seen);
    end
    div_int  = 16'd10;
    div_frac = 4'd0;
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    wait_ev(0, 400, n);
    n_checks++;
    if (n !== 124) begin
      n_fail++;
      $display("FAIL load_mid_current: got %0d want 124", n);
    end
    wait_ev(0, 40, n);
    n_checks++;
    if (n !== 10) begin
      n_fail++;
      $display("FAIL load_mid_new1: got %0d want 10", n);
    end
    wait_ev(0, 40, n);
    n_checks++;
    if (n !== 10) begin
      n_fail++;
      $display("FAIL load_mid_new2: got %0d want 10", n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    div_int  = 16'd7;
    div_load = 1'b1;
    @(negedge clk);
    div_int  = 16'd12;
    @(negedge clk);
    div_load = 1'b0;
    wait_ev(0, 40, n);
    n_checks++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL b2b_current: got %0d want 8", n);
    end
    wait_ev(0, 40, n);
    n_checks++;
    if (n !== 12) begin
      n_fail++;
      $display("FAIL b2b_last_write: got %0d want 12", n);
    end
  endtask

  task automatic test_restart_mid();
    int n;
    int tot;
    restart_with(10, 0);
    tot = 0;
    for (int i = 0; i < 9; i++) begin
      wait_ev(0, 40, n);
      tot += n;
    end
    n_checks++;
    if (tot !== 90) begin
      n_fail++;
      $display("FAIL restart_pre_ticks: got %0d want 90", tot);
    end
    repeat (9) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    n_checks++;
    if (os_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_cycle_tick: got %b want 0", os_tick);
    end
    wait_ev(1, 400, n);
    n_checks++;
    if (n !== 80) begin
      n_fail++;
      $display("FAIL restart_mid: got %0d want 80", n);
    end
    wait_ev(2, 400, n);
    n_checks++;
    if (n !== 80) begin
      n_fail++;
      $display("FAIL restart_bit: got %0d want 80", n);
    end
  endtask

  task automatic test_enable();
    int n;
    int seen;
    restart_with(10, 0);
    repeat (3) @(negedge clk);
    en   = 1'b0;
    seen = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (os_tick === 1'b1 || mid_tick === 1'b1 || bit_tick === 1'b1) seen++;
      if (i == 10) begin
        div_int  = 16'd20;
        div_load = 1'b1;
      end
      if (i == 11) div_load = 1'b0;
    end
    en = 1'b1;
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL enable_low_ticks: got %0d want 0", seen);
    end
    wait_ev(0, 40, n);
    n_checks++;
    if (n !== 7) begin
      n_fail++;
      $display("FAIL enable_delay: got %0d want 7", n);
    end
    wait_ev(0, 40, n);
    n_checks++;
    if (n !== 20) begin
      n_fail++;
      $display("FAIL enable_load_while_low: got %0d want 20", n);
    end
  endtask

  task automatic test_frac();
    int n;
    int p2;
    int tot;
    restart_with(4, 8);
    wait_ev(0, 40, n);
    n_checks++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL frac_restart_period: got %0d want 4", n);
    end
    tot = 0;
    p2  = -1;
    for (int i = 0; i < 16; i++) begin
      wait_ev(0, 40, n);
      if (i == 1) p2 = n;
      tot += n;
    end
    n_checks++;
    if (p2 !== EXP_FRAC_P2) begin
      n_fail++;
      $display("FAIL frac_second_period: got %0d want %0d", p2, EXP_FRAC_P2);
    end
    n_checks++;
    if (tot !== EXP_FRAC_TOT) begin
      n_fail++;
      $display("FAIL frac_16_ticks: got %0d want %0d", tot, EXP_FRAC_TOT);
    end
  endtask

  task automatic test_zero_div();
    int hits;
    restart_with(0, 0);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (os_tick === 1'b1) hits++;
    end
    n_checks++;
    if (hits !== 8) begin
      n_fail++;
      $display("FAIL zero_div_every_cycle: got %0d want 8", hits);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    restart_with(10, 0);
    wait_ev(0, 40, n);
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({os_tick, mid_tick, bit_tick} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_async_clear: got %b want 000", {os_tick, mid_tick, bit_tick});
    end
    @(negedge clk);
    reset = 1'b0;
    wait_ev(0, 400, n);
    n_checks++;
    if (n !== 325) begin
      n_fail++;
      $display("FAIL reset_mid_restore_div: got %0d want 325", n);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_load_mid();
    test_back_to_back();
    test_restart_mid();
    test_enable();
    test_frac();
    test_zero_div();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
